// File: rtl/sd_spi_card_responder.sv
// sd_spi_card_responder
//   SPI-mode SD card model (card side). Decodes 6-byte command frames and
//   answers CMD0/8/55/41/17/24 with R1/R7 responses, single-block reads from
//   and single-block writes to an external synchronous byte RAM.
//
// Ports
//   i_CLOCK50    system clock
//   i_RESET      synchronous, active-high reset
//   i_SCLK       SPI clock from host (asynchronous, <= CLOCK50/8)
//   i_MOSI       host-to-card data
//   i_CS         chip select, active low
//   o_MISO       card-to-host data
//   o_MEM_ADDR   RAM byte address {block_arg, byte_index}
//   o_MEM_WDATA  RAM write data
//   o_MEM_WE     RAM write strobe, one cycle per byte
//   i_MEM_RDATA  RAM read data, valid one cycle after o_MEM_ADDR
//   o_CARD_READY high once initialisation has completed
`timescale 1ns/1ps
module sd_spi_card_responder #(
    parameter int ADDR_W     = 16,
    parameter int NCR        = 1,
    parameter int INIT_POLLS = 3,
    parameter int ACCESS_GAP = 2,
    parameter int BUSY_BYTES = 4
) (
    input  logic              i_CLOCK50,
    input  logic              i_RESET,
    input  logic              i_SCLK,
    input  logic              i_MOSI,
    input  logic              i_CS,
    output logic              o_MISO,
    output logic [ADDR_W-1:0] o_MEM_ADDR,
    output logic [7:0]        o_MEM_WDATA,
    output logic              o_MEM_WE,
    input  logic [7:0]        i_MEM_RDATA,
    output logic              o_CARD_READY
);

    localparam logic [5:0] CMD0  = 6'd0;
    localparam logic [5:0] CMD8  = 6'd8;
    localparam logic [5:0] CMD17 = 6'd17;
    localparam logic [5:0] CMD24 = 6'd24;
    localparam logic [5:0] CMD41 = 6'd41;
    localparam logic [5:0] CMD55 = 6'd55;

    typedef enum logic [3:0] {
        S_HUNT, S_ARG, S_CRC, S_NCR, S_R1, S_R7,
        S_RD_GAP, S_RD_TOK, S_RD_DATA, S_RD_CRC,
        S_WR_TOK, S_WR_DATA, S_WR_CRC, S_WR_RESP, S_WR_BUSY
    } state_t;

    // Byte address = {arg, idx}, upper arg bits dropped by truncation.
    function automatic logic [ADDR_W-1:0] f_addr(input logic [31:0] arg,
                                                 input logic [8:0]  idx);
        logic [40:0] full;
        full = {arg, idx};
        return full[ADDR_W-1:0];
    endfunction

    // ---------------- input synchronisers ----------------
    logic [1:0] r_sclk_sync, r_mosi_sync, r_cs_sync;
    logic       r_sclk_prev;
    logic       w_desel, w_rise, w_fall, w_byte_done;
    logic [7:0] w_rx_byte;

    always_ff @(posedge i_CLOCK50) begin
        if (i_RESET) begin
            r_sclk_sync <= 2'b00;
            r_sclk_prev <= 1'b0;
            r_mosi_sync <= 2'b11;
            r_cs_sync   <= 2'b11;
        end else begin
            r_sclk_sync <= {r_sclk_sync[0], i_SCLK};
            r_sclk_prev <= r_sclk_sync[1];
            r_mosi_sync <= {r_mosi_sync[0], i_MOSI};
            r_cs_sync   <= {r_cs_sync[0], i_CS};
        end
    end

    // ---------------- byte engine ----------------
    logic [2:0] r_bit_cnt;
    logic [6:0] r_rx_sh;
    logic [7:0] r_tx_sh;
    logic [7:0] w_tx_byte;

    assign w_desel     = r_cs_sync[1];
    assign w_rise      = ~w_desel &  r_sclk_sync[1] & ~r_sclk_prev;
    assign w_fall      = ~w_desel & ~r_sclk_sync[1] &  r_sclk_prev;
    assign w_byte_done = w_rise & (r_bit_cnt == 3'd7);
    assign w_rx_byte   = {r_rx_sh, r_mosi_sync[1]};

    // TX byte is reloaded on the falling edge that follows the 8th rising
    // edge; the FSM has had several CLOCK50 cycles to pick it by then. While
    // deselected the register holds 0xFF so bit 7 of the first byte is
    // already on MISO when CS falls.
    always_ff @(posedge i_CLOCK50) begin
        if (i_RESET || w_desel) begin
            r_bit_cnt <= 3'd0;
            r_rx_sh   <= 7'd0;
            r_tx_sh   <= 8'hFF;
        end else begin
            if (w_rise) begin
                r_rx_sh   <= w_rx_byte[6:0];
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_fall)
                r_tx_sh <= (r_bit_cnt == 3'd0) ? w_tx_byte : {r_tx_sh[6:0], 1'b1};
        end
    end

    assign o_MISO = r_tx_sh[7];

    // ---------------- card state ----------------
    state_t            r_state, w_state_nxt;
    logic [9:0]        r_cnt, w_cnt_nxt;
    logic [5:0]        r_cmd;
    logic [31:0]       r_arg;
    logic              r_idle, r_app;
    logic [7:0]        r_poll;
    logic [8:0]        w_poll_inc;
    logic              w_poll_early;
    logic [7:0]        w_r1;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_mem_wdata;
    logic              r_mem_we;

    assign w_poll_inc   = {1'b0, r_poll} + 9'd1;
    assign w_poll_early = (w_poll_inc <= 9'(INIT_POLLS));

    always_ff @(posedge i_CLOCK50) begin
        if (i_RESET || w_desel) begin
            r_state <= S_HUNT;
            r_cnt   <= 10'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_r1        = {5'd0, 1'b1, 1'b0, r_idle};
        w_tx_byte   = 8'hFF;

        case (r_cmd)
            CMD0:         w_r1 = 8'h01;
            CMD8, CMD55:  w_r1 = {7'd0, r_idle};
            CMD41:        if (r_app) w_r1 = w_poll_early ? 8'h01 : 8'h00;
            CMD17, CMD24: w_r1 = r_idle ? 8'h05 : 8'h00;
            default: ;
        endcase

        // Byte to present in the period described by the current state.
        case (r_state)
            S_R1:      w_tx_byte = w_r1;
            S_R7:      w_tx_byte = (r_cnt == 10'd2) ? 8'h01 :
                                   (r_cnt == 10'd3) ? r_arg[7:0] : 8'h00;
            S_RD_TOK:  w_tx_byte = 8'hFE;
            S_RD_DATA: w_tx_byte = i_MEM_RDATA;
            S_WR_RESP: w_tx_byte = 8'h05;
            S_WR_BUSY: w_tx_byte = 8'h00;
            default: ;
        endcase

        if (w_byte_done) begin
            w_cnt_nxt = r_cnt + 10'd1;
            case (r_state)
                S_HUNT:
                    if (w_rx_byte[7:6] == 2'b01) begin
                        w_state_nxt = S_ARG;
                        w_cnt_nxt   = 10'd0;
                    end
                S_ARG:
                    if (r_cnt == 10'd3) w_state_nxt = S_CRC;
                S_CRC: begin
                    w_cnt_nxt   = 10'd0;
                    w_state_nxt = (NCR == 0) ? S_R1 : S_NCR;
                end
                S_NCR:
                    if (r_cnt == 10'(NCR - 1)) w_state_nxt = S_R1;
                S_R1: begin
                    w_cnt_nxt = 10'd0;
                    if (r_cmd == CMD8)
                        w_state_nxt = S_R7;
                    else if (r_cmd == CMD17 && !r_idle)
                        w_state_nxt = (ACCESS_GAP == 0) ? S_RD_TOK : S_RD_GAP;
                    else if (r_cmd == CMD24 && !r_idle)
                        w_state_nxt = S_WR_TOK;
                    else
                        w_state_nxt = S_HUNT;
                end
                S_R7:
                    if (r_cnt == 10'd3) w_state_nxt = S_HUNT;
                S_RD_GAP:
                    if (r_cnt == 10'(ACCESS_GAP - 1)) w_state_nxt = S_RD_TOK;
                S_RD_TOK: begin
                    w_state_nxt = S_RD_DATA;
                    w_cnt_nxt   = 10'd0;
                end
                S_RD_DATA:
                    if (r_cnt == 10'd511) begin
                        w_state_nxt = S_RD_CRC;
                        w_cnt_nxt   = 10'd0;
                    end
                S_RD_CRC:
                    if (r_cnt == 10'd1) w_state_nxt = S_HUNT;
                S_WR_TOK:
                    if (w_rx_byte == 8'hFE) begin
                        w_state_nxt = S_WR_DATA;
                        w_cnt_nxt   = 10'd0;
                    end else if (w_rx_byte != 8'hFF) begin
                        w_state_nxt = S_HUNT;
                    end
                S_WR_DATA:
                    if (r_cnt == 10'd511) begin
                        w_state_nxt = S_WR_CRC;
                        w_cnt_nxt   = 10'd0;
                    end
                S_WR_CRC:
                    if (r_cnt == 10'd1) w_state_nxt = S_WR_RESP;
                S_WR_RESP: begin
                    w_cnt_nxt   = 10'd0;
                    w_state_nxt = (BUSY_BYTES == 0) ? S_HUNT : S_WR_BUSY;
                end
                S_WR_BUSY:
                    if (r_cnt == 10'(BUSY_BYTES - 1)) w_state_nxt = S_HUNT;
                default: w_state_nxt = S_HUNT;
            endcase
        end
    end

    // Command fields, init flags and RAM interface. Flags change only once
    // the R1 byte has been shifted out, so R1 always reflects the state
    // before the command took effect.
    always_ff @(posedge i_CLOCK50) begin
        if (i_RESET) begin
            r_cmd       <= 6'd0;
            r_arg       <= 32'd0;
            r_idle      <= 1'b1;
            r_app       <= 1'b0;
            r_poll      <= 8'd0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 8'd0;
            r_mem_we    <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            if (w_byte_done) begin
                case (r_state)
                    S_HUNT:
                        if (w_rx_byte[7:6] == 2'b01) r_cmd <= w_rx_byte[5:0];
                    S_ARG:
                        r_arg <= {r_arg[23:0], w_rx_byte};
                    S_R1: begin
                        if (r_cmd == CMD0) begin
                            r_idle <= 1'b1;
                            r_poll <= 8'd0;
                        end
                        if (r_cmd == CMD55)
                            r_app <= 1'b1;
                        else if (r_cmd != CMD41)
                            r_app <= 1'b0;
                        if (r_cmd == CMD41 && r_app) begin
                            if (r_poll != 8'hFF) r_poll <= r_poll + 8'd1;
                            if (!w_poll_early) r_idle <= 1'b0;
                        end
                    end
                    S_WR_DATA: begin
                        r_mem_we    <= 1'b1;
                        r_mem_wdata <= w_rx_byte;
                        r_mem_addr  <= f_addr(r_arg, r_cnt[8:0]);
                    end
                    default: ;
                endcase
                // Read address leads the TX load by the falling-edge delay.
                if (w_state_nxt == S_RD_DATA)
                    r_mem_addr <= f_addr(r_arg, w_cnt_nxt[8:0]);
            end
        end
    end

    assign o_MEM_ADDR   = r_mem_addr;
    assign o_MEM_WDATA  = r_mem_wdata;
    // Gated so a write strobe in flight drops in the same cycle as RESET.
    assign o_MEM_WE     = r_mem_we & ~i_RESET;
    assign o_CARD_READY = ~r_idle;

endmodule

// File: tb/tb_sd_spi_card_responder.sv
`timescale 1ns/1ps
module tb_sd_spi_card_responder;
    localparam int ADDR_W     = 16;
    localparam int INIT_POLLS = 3;
    localparam int HALF       = 5;   // SCLK half period in CLOCK50 cycles

    logic              clk = 1'b0, rst = 1'b1, sclk = 1'b0, mosi = 1'b1, cs = 1'b1;
    logic              miso, we, ready;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wdata, rdata;

    logic [7:0]  mem [0:(1<<ADDR_W)-1];
    logic [7:0]  exp_q [$];           // expected MISO bytes
    logic [23:0] wr_exp [$];          // expected {addr,data} writes
    logic [23:0] wr_log [$];          // observed {addr,data} writes
    int checks = 0;
    int errors = 0;

    sd_spi_card_responder #(.ADDR_W(ADDR_W), .NCR(1), .INIT_POLLS(INIT_POLLS),
                            .ACCESS_GAP(2), .BUSY_BYTES(4)) dut (
        .i_CLOCK50(clk), .i_RESET(rst), .i_SCLK(sclk), .i_MOSI(mosi), .i_CS(cs),
        .o_MISO(miso), .o_MEM_ADDR(addr), .o_MEM_WDATA(wdata), .o_MEM_WE(we),
        .i_MEM_RDATA(rdata), .o_CARD_READY(ready));

    always #10 clk = ~clk;

    always @(posedge clk) begin
        rdata <= mem[addr];
        if (we) begin
            mem[addr] <= wdata;
            wr_log.push_back({addr, wdata});
        end
    end

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic spi_xfer(input logic [7:0] tx, output logic [7:0] rx);
        for (int b = 7; b >= 0; b--) begin
            mosi = tx[b];
            repeat (HALF) @(negedge clk);
            rx[b] = miso;
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
        mosi = 1'b1;
    endtask

    task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc);
        logic [7:0] rx;
        spi_xfer({2'b01, idx}, rx);
        spi_xfer(arg[31:24], rx);
        spi_xfer(arg[23:16], rx);
        spi_xfer(arg[15:8], rx);
        spi_xfer(arg[7:0], rx);
        spi_xfer(crc, rx);
    endtask

    task automatic cs_low();
        cs = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (miso !== 1'b1)  begin errors++; $display("FAIL reset_miso got %b want 1", miso); end
        checks++; if (we !== 1'b0)    begin errors++; $display("FAIL reset_we got %b want 0", we); end
        checks++; if (addr !== '0)    begin errors++; $display("FAIL reset_addr got %h want 0", addr); end
        checks++; if (wdata !== 8'h0) begin errors++; $display("FAIL reset_wdata got %h want 0", wdata); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_cmd0();
        logic [7:0] rx, e;
        int n = 0;
        cs_low();
        send_cmd(6'd0, 32'h0, 8'h95);
        exp_q.push_back(8'hFF); exp_q.push_back(8'h01); exp_q.push_back(8'hFF);
        while (exp_q.size() > 0) begin
            spi_xfer(8'hFF, rx);
            e = exp_q.pop_front();
            checks++;
            if (rx !== e) begin errors++; $display("FAIL cmd0_resp[%0d] got %02h want %02h", n, rx, e); end
            n++;
        end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL cmd0_ready got %b want 0", ready); end
    endtask

    task automatic test_cmd8();
        logic [7:0] rx, e;
        int n = 0;
        send_cmd(6'd8, 32'h0000_01AA, 8'h87);
        exp_q.push_back(8'hFF); exp_q.push_back(8'h01);
        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        exp_q.push_back(8'h01); exp_q.push_back(8'hAA);
        exp_q.push_back(8'hFF);
        while (exp_q.size() > 0) begin
            spi_xfer(8'hFF, rx);
            e = exp_q.pop_front();
            checks++;
            if (rx !== e) begin errors++; $display("FAIL cmd8_resp[%0d] got %02h want %02h", n, rx, e); end
            n++;
        end
    endtask

    task automatic test_init();
        logic [7:0] rx, e;
        for (int r = 0; r <= INIT_POLLS; r++) begin
            send_cmd(6'd55, 32'h0, 8'h65);
            exp_q.push_back(8'hFF); exp_q.push_back(8'h01);
            while (exp_q.size() > 0) begin
                spi_xfer(8'hFF, rx);
                e = exp_q.pop_front();
                checks++;
                if (rx !== e) begin errors++; $display("FAIL cmd55_resp poll %0d got %02h want %02h", r, rx, e); end
            end
            send_cmd(6'd41, 32'h4000_0000, 8'h77);
            exp_q.push_back(8'hFF);
            exp_q.push_back((r < INIT_POLLS) ? 8'h01 : 8'h00);
            while (exp_q.size() > 0) begin
                spi_xfer(8'hFF, rx);
                e = exp_q.pop_front();
                checks++;
                if (rx !== e) begin errors++; $display("FAIL acmd41_resp poll %0d got %02h want %02h", r, rx, e); end
            end
            repeat (4) @(negedge clk);
            checks++;
            if (ready !== (r == INIT_POLLS)) begin
                errors++; $display("FAIL init_ready poll %0d got %b want %b", r, ready, (r == INIT_POLLS));
            end
        end
    endtask

    task automatic test_read();
        logic [7:0] rx, e;
        int n = 0;
        for (int i = 0; i < 512; i++) mem[16'h0400 + i] = 8'(i);
        wr_log.delete();
        send_cmd(6'd17, 32'h0000_0002, 8'hFF);
        exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF); exp_q.push_back(8'hFF); exp_q.push_back(8'hFE);
        for (int i = 0; i < 512; i++) exp_q.push_back(8'(i));
        exp_q.push_back(8'hFF); exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
        while (exp_q.size() > 0) begin
            spi_xfer(8'hFF, rx);
            e = exp_q.pop_front();
            checks++;
            if (rx !== e) begin errors++; $display("FAIL read_resp[%0d] got %02h want %02h", n, rx, e); end
            n++;
        end
        checks++;
        if (wr_log.size() != 0) begin errors++; $display("FAIL read_no_write got %0d writes want 0", wr_log.size()); end
    endtask

    task automatic test_write();
        logic [7:0]  rx, e;
        logic [23:0] got, want;
        int n = 0;
        wr_log.delete();
        send_cmd(6'd24, 32'h0000_0001, 8'hFF);
        exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
        while (exp_q.size() > 0) begin
            spi_xfer(8'hFF, rx);
            e = exp_q.pop_front();
            checks++;
            if (rx !== e) begin errors++; $display("FAIL write_r1 got %02h want %02h", rx, e); end
        end
        spi_xfer(8'hFE, rx);
        for (int i = 0; i < 512; i++) begin
            wr_exp.push_back({16'(16'h0200 + i), 8'hA5});
            spi_xfer(8'hA5, rx);
        end
        spi_xfer(8'hFF, rx);
        spi_xfer(8'hFF, rx);
        exp_q.push_back(8'h05);
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        while (exp_q.size() > 0) begin
            spi_xfer(8'hFF, rx);
            e = exp_q.pop_front();
            checks++;
            if (rx !== e) begin errors++; $display("FAIL write_resp[%0d] got %02h want %02h", n, rx, e); end
            n++;
        end
        checks++;
        if (wr_log.size() != 512) begin errors++; $display("FAIL write_count got %0d want 512", wr_log.size()); end
        n = 0;
        while (wr_exp.size() > 0 && wr_log.size() > 0) begin
            got  = wr_log.pop_front();
            want = wr_exp.pop_front();
            checks++;
            if (got !== want) begin errors++; $display("FAIL write_entry[%0d] got %h want %h", n, got, want); end
            n++;
        end
        wr_exp.delete();
    endtask

    task automatic test_abort();
        logic [7:0]  rx, e;
        logic [23:0] got, want;
        wr_log.delete();
        send_cmd(6'd24, 32'h0000_0003, 8'hFF);
        exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
        while (exp_q.size() > 0) begin
            spi_xfer(8'hFF, rx);
            e = exp_q.pop_front();
            checks++;
            if (rx !== e) begin errors++; $display("FAIL abort_r1 got %02h want %02h", rx, e); end
        end
        spi_xfer(8'hFE, rx);
        for (int i = 0; i < 100; i++) begin
            wr_exp.push_back({16'(16'h0600 + i), 8'h3C});
            spi_xfer(8'h3C, rx);
        end
        cs = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (miso !== 1'b1) begin errors++; $display("FAIL abort_miso_idle got %b want 1", miso); end
        checks++;
        if (wr_log.size() != 100) begin errors++; $display("FAIL abort_count got %0d want 100", wr_log.size()); end
        while (wr_exp.size() > 0 && wr_log.size() > 0) begin
            got  = wr_log.pop_front();
            want = wr_exp.pop_front();
            checks++;
            if (got !== want) begin errors++; $display("FAIL abort_entry got %h want %h", got, want); end
        end
        wr_exp.delete();
        wr_log.delete();
        cs_low();
        send_cmd(6'd0, 32'h0, 8'h95);
        exp_q.push_back(8'hFF); exp_q.push_back(8'h01); exp_q.push_back(8'hFF);
        while (exp_q.size() > 0) begin
            spi_xfer(8'hFF, rx);
            e = exp_q.pop_front();
            checks++;
            if (rx !== e) begin errors++; $display("FAIL abort_cmd0 got %02h want %02h", rx, e); end
        end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL abort_ready got %b want 0", ready); end
        send_cmd(6'd17, 32'h0000_0002, 8'hFF);
        exp_q.push_back(8'hFF); exp_q.push_back(8'h05);
        exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
        while (exp_q.size() > 0) begin
            spi_xfer(8'hFF, rx);
            e = exp_q.pop_front();
            checks++;
            if (rx !== e) begin errors++; $display("FAIL idle_cmd17 got %02h want %02h", rx, e); end
        end
        checks++;
        if (wr_log.size() != 0) begin errors++; $display("FAIL abort_late_write got %0d want 0", wr_log.size()); end
    endtask

    initial begin
        test_reset();
        test_cmd0();
        test_cmd8();
        test_init();
        test_read();
        test_write();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
